keypad_emulator: RTL
====================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 The block SHALL have parameter BOUNCE_CYCLES, default 20, giving the number of cycles in each press and release bounce window.
REQ-002 The block SHALL have parameter LFSR_SEED, default 8'hA5, giving the nonzero bounce LFSR reset value.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 col  input  4  column drive from the scanner, active-high; multiple bits high permitted.
REQ-006 row  output  4  emulated keypad row sense, active-high.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  emulator can accept a command.
REQ-009 cmd_keys  input  16  mask of keys to hold; bit index = row*4 + col.
REQ-010 cmd_hold  input  16  stable-hold duration in cycles.
REQ-011 cmd_gap  input  16  all-released idle duration in cycles after release.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 done  output  1  one-cycle pulse at command completion.

Function
REQ-014 The FSM SHALL have states IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE and GAP.
REQ-015 A command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_ready SHALL equal (state == IDLE).
REQ-016 On accept, cmd_keys, cmd_hold and cmd_gap SHALL be latched; inputs SHALL be ignored until the next IDLE.
REQ-017 The state SHALL leave IDLE on the edge after accept, so row can reflect the command one cycle after accept.
REQ-018 The effective mask SHALL be 0 in IDLE and GAP, the latched mask in HOLD, and latched mask AND {16{lfsr[0]}} in both bounce states.
REQ-019 row[r] SHALL be the combinational OR over c of (eff[r*4+c] && col[c]), giving zero latency from col to row.
REQ-020 PRESS_BOUNCE and RELEASE_BOUNCE SHALL each last exactly BOUNCE_CYCLES cycles, with the LFSR advancing once per cycle in those states.
REQ-021 HOLD SHALL last exactly cmd_hold cycles; cmd_hold = 0 SHALL be treated as 1.
REQ-022 GAP SHALL last exactly cmd_gap cycles; cmd_gap = 0 SHALL skip GAP, going from RELEASE_BOUNCE to IDLE.
REQ-023 done SHALL pulse on the cycle the state first returns to IDLE; a new command SHALL be acceptable on that same cycle.
REQ-024 The 16-bit down-counter SHALL be reloaded at each state entry and SHALL NOT wrap.
REQ-025 A zero cmd_keys SHALL run the full timed sequence with row held at 0.
REQ-026 With col = 0, row SHALL be 0 in every state.

Reset
REQ-027 When reset is low at a clock edge: state = IDLE, counter = 0, latched mask = 0, lfsr = LFSR_SEED, done = 0.
REQ-028 After reset: row = 0, cmd_ready = 1, busy = 0.
REQ-029 Reset mid-command SHALL abort the command with no done pulse; row SHALL be 0 from the following cycle.

Configuration
REQ-030 With KEYPAD_BOUNCE_EN defined, the bounce states and LFSR SHALL be present as specified above.
REQ-031 Without KEYPAD_BOUNCE_EN, PRESS_BOUNCE and RELEASE_BOUNCE SHALL be skipped (IDLE to HOLD, HOLD to GAP or IDLE), the LFSR SHALL be omitted, and BOUNCE_CYCLES SHALL be ignored.

Structure
REQ-032 Package keypad_pkg SHALL hold NUM_ROWS = 4, NUM_COLS = 4, the keypad_state_t enum and the key index function (row*4 + col).
REQ-033 The block SHALL use one sub-module, bounce_lfsr: an 8-bit Fibonacci LFSR (taps 8,6,5,4) with enable and seed, instantiated only under KEYPAD_BOUNCE_EN.

Verification
REQ-034 Reset low 2 cycles, then high -> row = 0, cmd_ready = 1, busy = 0, done = 0.
REQ-035 Bounce off, keys = 16'h0020 (row 1, col 1), hold = 50, gap = 10, col walking one-hot -> row = 4'b0010 only while col = 4'b0010 for exactly 50 cycles; done 11 cycles after HOLD ends.
REQ-036 Bounce on, BOUNCE_CYCLES = 20, same command -> row[1] toggles per lfsr during 20 cycles each side of a clean 50-cycle hold; total busy = 20 + 50 + 20 + 10 cycles.
REQ-037 Keys = 16'h0011 (rows 0 and 1, col 0), col = 4'b0001 held -> row = 4'b0011 during HOLD; with col = 4'b0010 -> row = 0.
REQ-038 hold = 0, gap = 0 -> HOLD lasts 1 cycle, GAP skipped; back-to-back command accepted on the done cycle.
REQ-039 reset low during HOLD of a hold = 1000 command -> no done pulse; row = 0 next cycle; cmd_ready = 1.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: matrix geometry, FSM state
// encoding, key indexing and the duration-to-counter-load helper.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESS_BOUNCE   = 3'd1,
    HOLD           = 3'd2,
    RELEASE_BOUNCE = 3'd3,
    GAP            = 3'd4
  } keypad_state_t;

  // Bit position of a key in the 16-bit key mask.
  function automatic int key_index(input int r, input int c);
    return r * NUM_COLS + c;
  endfunction

  // A state lasting d cycles loads d-1 and leaves when the counter reads 0.
  // A zero duration collapses to a single cycle.
  function automatic logic [15:0] dur_load(input logic [15:0] d);
    return (d == 16'd0) ? 16'd0 : d - 16'd1;
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to scramble the key contacts
// while a press or release is bouncing. Advances only when en is high.
module bounce_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_reg;
  logic       feedback;

  assign feedback = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign lfsr     = lfsr_reg;

  // Shift register: reload seed on reset, step once per enabled cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_reg <= SEED;
    end else if (en) begin
      lfsr_reg <= {lfsr_reg[6:0], feedback};
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: plays back a timed key press (optional bounce, clean
// hold, optional bounce, idle gap) onto a 4x4 matrix sensed by an external
// column scanner. Row sense is combinational from col.
// Build option: define KEYPAD_BOUNCE_EN to add the press/release bounce
// states driven by the bounce_lfsr; otherwise the FSM goes IDLE -> HOLD
// -> GAP/IDLE and BOUNCE_CYCLES/LFSR_SEED have no effect.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int         BOUNCE_CYCLES = 20,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_keys,
  input  logic [15:0] cmd_hold,
  input  logic [15:0] cmd_gap,
  output logic        busy,
  output logic        done
);

  // A zero-length bounce window is treated as one cycle.
  localparam logic [15:0] BOUNCE_LOAD =
    (BOUNCE_CYCLES > 1) ? 16'(BOUNCE_CYCLES - 1) : 16'd0;

  keypad_state_t state_reg;
  logic [15:0]   count_reg;
  logic [15:0]   keys_reg;
  logic [15:0]   hold_reg;
  logic [15:0]   gap_reg;
  logic          done_reg;
  logic [15:0]   eff_mask;
  logic          bounce_bit;

`ifdef KEYPAD_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;

  logic [7:0] lfsr;
  logic [6:0] lfsr_unused;
  logic       lfsr_en;

  assign lfsr_en     = (state_reg == PRESS_BOUNCE) || (state_reg == RELEASE_BOUNCE);
  assign bounce_bit  = lfsr[0];
  assign lfsr_unused = lfsr[7:1];

  bounce_lfsr #(
    .SEED (LFSR_SEED)
  ) u_bounce_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .lfsr  (lfsr)
  );
`else
  localparam bit BOUNCE_EN = 1'b0;

  logic [7:0] seed_unused;

  assign bounce_bit  = 1'b0;
  assign seed_unused = LFSR_SEED;
`endif

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

  // Command sequencer: latches the command, times each phase with a
  // down-counter reloaded on every state entry, pulses done on return to IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= 16'd0;
      keys_reg  <= 16'd0;
      hold_reg  <= 16'd0;
      gap_reg   <= 16'd0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            keys_reg <= cmd_keys;
            hold_reg <= cmd_hold;
            gap_reg  <= cmd_gap;
            if (BOUNCE_EN) begin
              state_reg <= PRESS_BOUNCE;
              count_reg <= BOUNCE_LOAD;
            end else begin
              state_reg <= HOLD;
              count_reg <= dur_load(cmd_hold);
            end
          end
        end

        PRESS_BOUNCE: begin
          if (count_reg == 16'd0) begin
            state_reg <= HOLD;
            count_reg <= dur_load(hold_reg);
          end else begin
            count_reg <= count_reg - 16'd1;
          end
        end

        HOLD: begin
          if (count_reg == 16'd0) begin
            if (BOUNCE_EN) begin
              state_reg <= RELEASE_BOUNCE;
              count_reg <= BOUNCE_LOAD;
            end else if (gap_reg != 16'd0) begin
              state_reg <= GAP;
              count_reg <= gap_reg - 16'd1;
            end else begin
              state_reg <= IDLE;
              count_reg <= 16'd0;
              done_reg  <= 1'b1;
            end
          end else begin
            count_reg <= count_reg - 16'd1;
          end
        end

        RELEASE_BOUNCE: begin
          if (count_reg == 16'd0) begin
            if (gap_reg != 16'd0) begin
              state_reg <= GAP;
              count_reg <= gap_reg - 16'd1;
            end else begin
              state_reg <= IDLE;
              count_reg <= 16'd0;
              done_reg  <= 1'b1;
            end
          end else begin
            count_reg <= count_reg - 16'd1;
          end
        end

        GAP: begin
          if (count_reg == 16'd0) begin
            state_reg <= IDLE;
            count_reg <= 16'd0;
            done_reg  <= 1'b1;
          end else begin
            count_reg <= count_reg - 16'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          count_reg <= 16'd0;
        end
      endcase
    end
  end

  // Effective contact mask: closed keys in HOLD, LFSR-chopped while bouncing.
  always_comb begin
    eff_mask = 16'd0;
    case (state_reg)
      HOLD:                         eff_mask = keys_reg;
      PRESS_BOUNCE, RELEASE_BOUNCE: eff_mask = keys_reg & {16{bounce_bit}};
      default:                      eff_mask = 16'd0;
    endcase
  end

  // Matrix sense: a row sees a driven column through any closed key on it.
  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    logic [NUM_COLS-1:0] hit;
    for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
      assign hit[gj] = eff_mask[key_index(gi, gj)] & col[gj];
    end
    assign row[gi] = |hit;
  end

endmodule
